// File: rtl/rv32im_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction cache and
// hands {instr, pc} to decode. Optional perf counters: RV32IM_FETCH_PERF_EN.
module rv32im_fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic [XLEN-1:0] cache_addr_o,
  output logic            cache_advance_o,
  output logic            cache_jump_o,
  input  logic            cache_busy_i,
  input  logic [ILEN-1:0] cache_instr_i,
  input  logic [XLEN-1:0] vtable_pc_i,
  input  logic            vtable_pc_write_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            exc_misalign_o,
  output logic [XLEN-1:0] exc_addr_o
`ifdef RV32IM_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_miss_o
`endif
);

  typedef enum logic [1:0] {S_ISSUE, S_CHECK, S_WAIT, S_HALT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pending_pc;
  logic            pending;
  logic            disc;

  logic            load_vt;
  logic            load_rd;
  logic            misalign;
  logic            load;
  logic            defer;
  logic [XLEN-1:0] load_pc;
  logic            accept;
  logic            issue;

  // The vector table outranks a redirect; only redirect targets are alignment-checked.
  assign load_vt  = vtable_pc_write_i;
  assign load_rd  = redirect_i & ~vtable_pc_write_i & (redirect_pc_i[1:0] == 2'b00);
  assign misalign = redirect_i & ~vtable_pc_write_i & (redirect_pc_i[1:0] != 2'b00);
  assign load     = load_vt | load_rd;
  assign load_pc  = load_vt ? vtable_pc_i : redirect_pc_i;
  assign defer    = load & cache_busy_i & ((state == S_CHECK) | (state == S_WAIT));
  assign accept   = valid_o & ready_i;

  // A request goes out only when the output register will have room for its data.
  assign issue = (state == S_ISSUE) & (~valid_o | ready_i) & ~cache_busy_i &
                 ~load & ~misalign & ~reset_i;

  assign cache_addr_o = pc;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= S_ISSUE;
    else         state <= state_next;
  end

  always_comb begin
    state_next      = state;
    cache_advance_o = 1'b0;
    cache_jump_o    = 1'b0;
    if (issue) begin
      cache_advance_o = ~disc;
      cache_jump_o    = disc;
    end
    case (state)
      S_ISSUE: if (issue) state_next = S_CHECK;
      S_CHECK: state_next = cache_busy_i ? S_WAIT : S_ISSUE;
      S_WAIT:  if (!cache_busy_i) state_next = S_ISSUE;
      S_HALT:  state_next = S_HALT;
    endcase
    if (misalign)            state_next = S_HALT;
    else if (load && !defer) state_next = S_ISSUE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc             <= RESET_PC;
      pending_pc     <= '0;
      pending        <= 1'b0;
      disc           <= 1'b0;
      valid_o        <= 1'b0;
      instr_o        <= '0;
      pc_o           <= '0;
      exc_misalign_o <= 1'b0;
      exc_addr_o     <= '0;
    end else begin
      exc_misalign_o <= misalign;
      if (issue) disc <= 1'b0;
      if (misalign) begin
        exc_addr_o <= redirect_pc_i;
        valid_o    <= 1'b0;
        pending    <= 1'b0;
      end else if (load) begin
        // A read may still be outstanding; park the target until the cache settles.
        valid_o <= 1'b0;
        disc    <= 1'b1;
        if (defer) begin
          pending    <= 1'b1;
          pending_pc <= load_pc;
        end else begin
          pc      <= load_pc;
          pending <= 1'b0;
        end
      end else begin
        if (state == S_CHECK && !cache_busy_i) begin
          valid_o <= 1'b1;
          instr_o <= cache_instr_i;
          pc_o    <= pc;
          pc      <= pc + XLEN'(4);
        end else if (accept) begin
          valid_o <= 1'b0;
        end
        if (state == S_WAIT && !cache_busy_i && pending) begin
          pc      <= pending_pc;
          pending <= 1'b0;
        end
      end
    end
  end

`ifdef RV32IM_FETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_stall_o <= '0;
      perf_miss_o  <= '0;
    end else begin
      if (state == S_WAIT) perf_stall_o <= perf_stall_o + 32'd1;
      if (state == S_CHECK && state_next == S_WAIT) perf_miss_o <= perf_miss_o + 32'd1;
    end
  end
`endif

endmodule
